// File: rtl/sd_img_pkg.sv
// Shared definitions for the SD-card image read/write sequencers:
// image placement on the card, sector geometry and the read FSM state type.
package sd_img_pkg;

    localparam logic [31:0] IMG_START_SEC = 32'd2000;
    localparam logic [10:0] IMG_SEC_NUM   = 11'd1200;
    localparam int          SEC_WORDS     = 256;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ROOM,
        WAIT_BUSY,
        WAIT_DONE
    } rd_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle
// rise/fall pulses derived from the two synchroniser stages.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic d0_reg;
    logic d1_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_reg <= 1'b0;
            d1_reg <= 1'b0;
        end else begin
            d0_reg <= din;
            d1_reg <= d0_reg;
        end
    end

    assign level = d0_reg;
    assign rise  = d0_reg & ~d1_reg;
    assign fall  = d1_reg & ~d0_reg;

endmodule

// File: rtl/sd_img_rd_ctrl.sv
// Sector-read sequencer streaming one stored image from the SD card to the display FIFO.
// Define SD_IMG_RD_AUTO_LOOP_EN to restart at the first sector after every frame.
module sd_img_rd_ctrl
    import sd_img_pkg::*;
#(
    parameter logic [31:0] START_ADDR  = IMG_START_SEC,
    parameter logic [10:0] SEC_NUM     = IMG_SEC_NUM,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        rd_req,
    input  logic        rd_busy,
    input  logic        fifo_ready,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    output logic        rd_active,
    output logic        frame_done,
    output logic        err_timeout
);

    rd_state_t   state_reg;
    logic [10:0] sec_cnt_reg;
    logic [23:0] timer_reg;

    logic init_level;
    logic pos_init;
    logic init_fall_unused;
    logic busy_level_unused;
    logic pos_busy;
    logic neg_busy;

    sync_edge_det u_init_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sd_init_done),
        .level (init_level),
        .rise  (pos_init),
        .fall  (init_fall_unused)
    );

    sync_edge_det u_busy_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rd_busy),
        .level (busy_level_unused),
        .rise  (pos_busy),
        .fall  (neg_busy)
    );

    logic timer_expired;
    logic last_sec;
    logic timeout_hit;

    assign timer_expired = (timer_reg == TIMEOUT_CYC - 24'd1);
    assign last_sec      = (sec_cnt_reg == SEC_NUM - 11'd1);
    // A busy edge arriving on the expiry cycle takes priority over the watchdog.
    assign timeout_hit   = timer_expired &&
                           ((state_reg == WAIT_BUSY && !pos_busy) ||
                            (state_reg == WAIT_DONE && !neg_busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sec_cnt_reg <= 11'd0;
            timer_reg   <= 24'd0;
            rd_start_en <= 1'b0;
            rd_sec_addr <= START_ADDR;
            rd_active   <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rd_start_en <= 1'b0;
            frame_done  <= 1'b0;
            if (state_reg == WAIT_BUSY || state_reg == WAIT_DONE) begin
                timer_reg <= timer_reg + 24'd1;
            end

            // Card loss overrides everything, including a completing last sector.
            if (!init_level) begin
                state_reg <= IDLE;
                rd_active <= 1'b0;
            end else if (timeout_hit) begin
                err_timeout <= 1'b1;
                rd_active   <= 1'b0;
                state_reg   <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (pos_init || rd_req) begin
                            rd_sec_addr <= START_ADDR;
                            sec_cnt_reg <= 11'd0;
                            err_timeout <= 1'b0;
                            rd_active   <= 1'b1;
                            state_reg   <= WAIT_ROOM;
                        end
                    end
                    WAIT_ROOM: begin
                        if (fifo_ready) begin
                            rd_start_en <= 1'b1;
                            timer_reg   <= 24'd0;
                            state_reg   <= WAIT_BUSY;
                        end
                    end
                    WAIT_BUSY: begin
                        if (pos_busy) begin
                            state_reg <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (neg_busy) begin
                            if (last_sec) begin
                                frame_done  <= 1'b1;
                                sec_cnt_reg <= 11'd0;
`ifdef SD_IMG_RD_AUTO_LOOP_EN
                                rd_sec_addr <= START_ADDR;
                                state_reg   <= WAIT_ROOM;
`else
                                rd_active   <= 1'b0;
                                state_reg   <= IDLE;
`endif
                            end else begin
                                sec_cnt_reg <= sec_cnt_reg + 11'd1;
                                rd_sec_addr <= rd_sec_addr + 32'd1;
                                state_reg   <= WAIT_ROOM;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
